// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//   Hardwired control unit. It runs the instruction fetch in T0..T2, then runs
//   the execute steps T3..T7 for the instruction class that IR[31:27] selects.
//   It drives the register-select strobes, the datapath load/drive strobes and
//   the memory request lines.
//
// Ports
//   clock, clear_n          : rising-edge clock, asynchronous active-low clear
//   opcode [OP_W-1:0]       : IR[31:27]; stable from T3 onward
//   con_ff                  : branch condition flop output
//   mem_rdy                 : memory finishes the current Read/Write this cycle
//   Gra/Grb/Grc             : register-field selects
//   Rin/Rout/BAout/Cout     : register file load/drive, base-address drive,
//                             sign-extended constant drive
//   PCout/PCin/IncPC        : PC strobes
//   MARin/MDRin/MDRout/IRin : datapath register strobes
//   Yin/Zin/Zlowout/CONin   : ALU staging strobes
//   Read/Write              : memory requests, held until mem_rdy
//   alu_op [OP_W-1:0]       : ALU operation, zero whenever Zin is low
//   run                     : high unless halted
//   illegal                 : one-cycle pulse in T3 on an unsupported opcode
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter int              OP_W    = 5,
  parameter logic [OP_W-1:0] ALU_ADD = 5'b00011
) (
  input  logic            clock,
  input  logic            clear_n,
  input  logic [OP_W-1:0] opcode,
  input  logic            con_ff,
  input  logic            mem_rdy,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic            Cout,
  output logic            PCout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            Zlowout,
  output logic            CONin,
  output logic            Read,
  output logic            Write,
  output logic [OP_W-1:0] alu_op,
  output logic            run,
  output logic            illegal
);

  // Opcode map
  localparam logic [OP_W-1:0] OP_LD   = OP_W'(5'b00000);
  localparam logic [OP_W-1:0] OP_LDI  = OP_W'(5'b00001);
  localparam logic [OP_W-1:0] OP_ST   = OP_W'(5'b00010);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(5'b00011);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(5'b00100);
  localparam logic [OP_W-1:0] OP_SHR  = OP_W'(5'b00101);
  localparam logic [OP_W-1:0] OP_SHL  = OP_W'(5'b00110);
  localparam logic [OP_W-1:0] OP_ROR  = OP_W'(5'b00111);
  localparam logic [OP_W-1:0] OP_ROL  = OP_W'(5'b01000);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(5'b01001);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(5'b01010);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(5'b01011);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(5'b01100);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(5'b01101);
  localparam logic [OP_W-1:0] OP_BR   = OP_W'(5'b10010);
  localparam logic [OP_W-1:0] OP_NOP  = OP_W'(5'b11001);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(5'b11010);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  // Instruction classes that share an execute sequence
  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_RALU, C_IMM, C_BR, C_NOP, C_HALT, C_ILL
  } iclass_t;

  state_t          r_state;
  state_t          w_next;
  iclass_t         w_cls;
  logic [OP_W-1:0] w_imm_op;

  // NOTE: asynchronous clear puts the FSM in RST at once; with every output
  // decoded from the state, all strobes (including a pending Read/Write) drop
  // in the same cycle as clear_n falls.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) r_state <= S_RST;
    else          r_state <= w_next;
  end

  // Opcode -> class, plus the ALU code each immediate op maps onto.
  always_comb begin
    // NOTE: each variable gets a default before the case, so a missing arm
    // falls back to a known value instead of inferring a latch.
    w_cls    = C_ILL;
    w_imm_op = ALU_ADD;
    case (opcode)
      OP_LD:   w_cls = C_LD;
      OP_LDI:  w_cls = C_LDI;
      OP_ST:   w_cls = C_ST;
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR:
               w_cls = C_RALU;
      OP_ADDI: w_cls = C_IMM;
      OP_ANDI: begin w_cls = C_IMM; w_imm_op = OP_AND; end
      OP_ORI:  begin w_cls = C_IMM; w_imm_op = OP_OR;  end
      OP_BR:   w_cls = C_BR;
      OP_NOP:  w_cls = C_NOP;
      OP_HALT: w_cls = C_HALT;
      default: w_cls = C_ILL;
    endcase
  end

  // Next state and strobes. alu_op is written only next to Zin, so it reads
  // zero in every cycle where Zin is low.
  always_comb begin
    w_next  = r_state;
    Gra     = 1'b0; Grb    = 1'b0; Grc   = 1'b0;
    Rin     = 1'b0; Rout   = 1'b0; BAout = 1'b0; Cout  = 1'b0;
    PCout   = 1'b0; PCin   = 1'b0; IncPC = 1'b0;
    MARin   = 1'b0; MDRin  = 1'b0; MDRout = 1'b0; IRin = 1'b0;
    Yin     = 1'b0; Zin    = 1'b0; Zlowout = 1'b0; CONin = 1'b0;
    Read    = 1'b0; Write  = 1'b0;
    alu_op  = '0;
    run     = 1'b1;
    illegal = 1'b0;

    case (r_state)
      S_RST: w_next = S_T0;

      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
        Zin = 1'b1; alu_op = ALU_ADD;
        w_next = S_T1;
      end

      // PC reload is tied to the completing cycle so a stalled fetch
      // does not write PC repeatedly.
      S_T1: begin
        Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
        PCin = mem_rdy;
        if (mem_rdy) w_next = S_T2;
      end

      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        w_next = S_T3;
      end

      S_T3: begin
        case (w_cls)
          C_RALU, C_IMM: begin
            Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; w_next = S_T4;
          end
          C_LDI, C_LD, C_ST: begin
            // Base address: BAout drives R0 as zero, so Rout stays low.
            Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; w_next = S_T4;
          end
          C_BR: begin
            Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; w_next = S_T4;
          end
          C_NOP:   w_next = S_T0;
          C_HALT:  w_next = S_HALT;
          default: begin illegal = 1'b1; w_next = S_T0; end
        endcase
      end

      S_T4: begin
        w_next = S_T5;
        case (w_cls)
          C_RALU: begin
            Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode;
          end
          C_IMM: begin
            Cout = 1'b1; Zin = 1'b1; alu_op = w_imm_op;
          end
          C_LDI, C_LD, C_ST: begin
            Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD;
          end
          C_BR: begin
            PCout = 1'b1; Yin = 1'b1;
          end
          default: w_next = S_T0;
        endcase
      end

      S_T5: begin
        case (w_cls)
          C_RALU, C_IMM, C_LDI: begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; w_next = S_T0;
          end
          C_LD, C_ST: begin
            Zlowout = 1'b1; MARin = 1'b1; w_next = S_T6;
          end
          C_BR: begin
            Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; w_next = S_T6;
          end
          default: w_next = S_T0;
        endcase
      end

      S_T6: begin
        case (w_cls)
          C_LD: begin
            Read = 1'b1; MDRin = 1'b1;
            if (mem_rdy) w_next = S_T7;
          end
          C_ST: begin
            Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; w_next = S_T7;
          end
          C_BR: begin
            Zlowout = 1'b1; PCin = con_ff; w_next = S_T0;
          end
          default: w_next = S_T0;
        endcase
      end

      S_T7: begin
        case (w_cls)
          C_LD: begin
            MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; w_next = S_T0;
          end
          C_ST: begin
            Write = 1'b1;
            if (mem_rdy) w_next = S_T0;
          end
          default: w_next = S_T0;
        endcase
      end

      S_HALT: run = 1'b0;

      default: w_next = S_RST;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//   Directed bench for control_sequencer. Each task restarts the sequencer,
//   applies an opcode plus a per-cycle mem_rdy pattern, and compares the full
//   output word every cycle against a hand-written table.
//   Output word = {20 strobes, alu_op[4:0], run, illegal}.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_control_sequencer;

  logic       clock = 1'b0;
  logic       clear_n = 1'b0;
  logic [4:0] opcode = 5'b00011;
  logic       con_ff = 1'b0;
  logic       mem_rdy = 1'b1;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC;
  logic MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, CONin, Read, Write;
  logic [4:0] alu_op;
  logic       run, illegal;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  control_sequencer #(.OP_W(5), .ALU_ADD(5'b00011)) dut (
    .clock(clock), .clear_n(clear_n), .opcode(opcode), .con_ff(con_ff),
    .mem_rdy(mem_rdy),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Cout(Cout), .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .CONin(CONin), .Read(Read), .Write(Write),
    .alu_op(alu_op), .run(run), .illegal(illegal)
  );

  // Strobe bit positions inside the 20-bit strobe field
  localparam logic [19:0] M_GRA   = 20'h80000, M_GRB   = 20'h40000;
  localparam logic [19:0] M_GRC   = 20'h20000, M_RIN   = 20'h10000;
  localparam logic [19:0] M_ROUT  = 20'h08000, M_BAOUT = 20'h04000;
  localparam logic [19:0] M_COUT  = 20'h02000, M_PCOUT = 20'h01000;
  localparam logic [19:0] M_PCIN  = 20'h00800, M_INCPC = 20'h00400;
  localparam logic [19:0] M_MARIN = 20'h00200, M_MDRIN = 20'h00100;
  localparam logic [19:0] M_MDROUT= 20'h00080, M_IRIN  = 20'h00040;
  localparam logic [19:0] M_YIN   = 20'h00020, M_ZIN   = 20'h00010;
  localparam logic [19:0] M_ZLOW  = 20'h00008, M_CONIN = 20'h00004;
  localparam logic [19:0] M_READ  = 20'h00002, M_WRITE = 20'h00001;

  localparam logic [4:0] A_ADD = 5'b00011;
  localparam logic [4:0] A_AND = 5'b01001;
  localparam logic [4:0] A_NONE = 5'b00000;

  // Full expected words: {strobes, alu_op, run, illegal}
  localparam logic [26:0] E_IDLE = {20'h0, A_NONE, 1'b1, 1'b0};
  localparam logic [26:0] E_HALT = {20'h0, A_NONE, 1'b0, 1'b0};
  localparam logic [26:0] E_ILL  = {20'h0, A_NONE, 1'b1, 1'b1};
  localparam logic [26:0] E_T0   = {M_PCOUT | M_MARIN | M_INCPC | M_ZIN, A_ADD, 1'b1, 1'b0};
  localparam logic [26:0] E_T1R  = {M_ZLOW | M_PCIN | M_READ | M_MDRIN, A_NONE, 1'b1, 1'b0};
  localparam logic [26:0] E_T1W  = {M_ZLOW | M_READ | M_MDRIN, A_NONE, 1'b1, 1'b0};
  localparam logic [26:0] E_T2   = {M_MDROUT | M_IRIN, A_NONE, 1'b1, 1'b0};
  localparam logic [26:0] E_AL3  = {M_GRB | M_ROUT | M_YIN, A_NONE, 1'b1, 1'b0};
  localparam logic [26:0] E_ADD4 = {M_GRC | M_ROUT | M_ZIN, A_ADD, 1'b1, 1'b0};
  localparam logic [26:0] E_WB5  = {M_ZLOW | M_GRA | M_RIN, A_NONE, 1'b1, 1'b0};
  localparam logic [26:0] E_BA3  = {M_GRB | M_BAOUT | M_YIN, A_NONE, 1'b1, 1'b0};
  localparam logic [26:0] E_C4   = {M_COUT | M_ZIN, A_ADD, 1'b1, 1'b0};
  localparam logic [26:0] E_MAR5 = {M_ZLOW | M_MARIN, A_NONE, 1'b1, 1'b0};
  localparam logic [26:0] E_RD6  = {M_READ | M_MDRIN, A_NONE, 1'b1, 1'b0};
  localparam logic [26:0] E_LD7  = {M_MDROUT | M_GRA | M_RIN, A_NONE, 1'b1, 1'b0};
  localparam logic [26:0] E_ST6  = {M_GRA | M_ROUT | M_MDRIN, A_NONE, 1'b1, 1'b0};
  localparam logic [26:0] E_WR7  = {M_WRITE, A_NONE, 1'b1, 1'b0};
  localparam logic [26:0] E_BR3  = {M_GRA | M_ROUT | M_CONIN, A_NONE, 1'b1, 1'b0};
  localparam logic [26:0] E_BR4  = {M_PCOUT | M_YIN, A_NONE, 1'b1, 1'b0};
  localparam logic [26:0] E_BR6T = {M_ZLOW | M_PCIN, A_NONE, 1'b1, 1'b0};
  localparam logic [26:0] E_BR6N = {M_ZLOW, A_NONE, 1'b1, 1'b0};
  localparam logic [26:0] E_ANDI4= {M_COUT | M_ZIN, A_AND, 1'b1, 1'b0};

  function automatic logic [26:0] obs();
    return {Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC,
            MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, CONin, Read, Write,
            alu_op, run, illegal};
  endfunction

  // Pulse clear_n for one cycle; the first negedge after return sees T0.
  task automatic do_reset();
    @(negedge clock);
    clear_n = 1'b0;
    @(negedge clock);
    clear_n = 1'b1;
  endtask

  task automatic test_reset();
    opcode = 5'b00011; mem_rdy = 1'b1; con_ff = 1'b0; clear_n = 1'b0;
    @(negedge clock); #1;
    checks++;
    if (obs() !== E_IDLE) begin
      errors++; $display("FAIL reset_hold got %h exp %h", obs(), E_IDLE);
    end
    clear_n = 1'b1;
    @(negedge clock); #1;
    checks++;
    if (obs() !== E_T0) begin
      errors++; $display("FAIL reset_first_t0 got %h exp %h", obs(), E_T0);
    end
    repeat (4) @(negedge clock);
    #1;
    checks++;
    if (obs() !== E_ADD4) begin
      errors++; $display("FAIL reset_pre_t4 got %h exp %h", obs(), E_ADD4);
    end
    clear_n = 1'b0;
    #1;
    checks++;
    if (obs() !== E_IDLE) begin
      errors++; $display("FAIL reset_mid_t4 got %h exp %h", obs(), E_IDLE);
    end
    @(negedge clock);
    clear_n = 1'b1;
    #1;
    checks++;
    if (obs() !== E_IDLE) begin
      errors++; $display("FAIL reset_rst_state got %h exp %h", obs(), E_IDLE);
    end
    @(negedge clock); #1;
    checks++;
    if (obs() !== E_T0) begin
      errors++; $display("FAIL reset_after_t0 got %h exp %h", obs(), E_T0);
    end
  endtask

  // add, with mem_rdy low during T3..T5 where it must be ignored
  task automatic test_add();
    logic [26:0] ex [7];
    bit          rdy [7];
    ex = '{E_T0, E_T1R, E_T2, E_AL3, E_ADD4, E_WB5, E_T0};
    rdy = '{1, 1, 1, 0, 0, 0, 1};
    opcode = 5'b00011;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      mem_rdy = rdy[i];
      #1;
      checks++;
      if (obs() !== ex[i]) begin
        errors++; $display("FAIL add cyc%0d got %h exp %h", i, obs(), ex[i]);
      end
    end
  endtask

  task automatic test_andi();
    logic [26:0] ex [7];
    ex = '{E_T0, E_T1R, E_T2, E_AL3, E_ANDI4, E_WB5, E_T0};
    opcode = 5'b01100; mem_rdy = 1'b1;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clock); #1;
      checks++;
      if (obs() !== ex[i]) begin
        errors++; $display("FAIL andi cyc%0d got %h exp %h", i, obs(), ex[i]);
      end
    end
  endtask

  // ld with three wait cycles in T6: 11 cycles then T0
  task automatic test_ld();
    logic [26:0] ex [12];
    bit          rdy [12];
    ex = '{E_T0, E_T1R, E_T2, E_BA3, E_C4, E_MAR5,
           E_RD6, E_RD6, E_RD6, E_RD6, E_LD7, E_T0};
    rdy = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    opcode = 5'b00000;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      mem_rdy = rdy[i];
      #1;
      checks++;
      if (obs() !== ex[i]) begin
        errors++; $display("FAIL ld cyc%0d got %h exp %h", i, obs(), ex[i]);
      end
    end
  endtask

  // st with one fetch wait in T1 and two write waits in T7
  task automatic test_st();
    logic [26:0] ex [12];
    bit          rdy [12];
    ex = '{E_T0, E_T1W, E_T1R, E_T2, E_BA3, E_C4, E_MAR5,
           E_ST6, E_WR7, E_WR7, E_WR7, E_T0};
    rdy = '{1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1};
    opcode = 5'b00010;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      mem_rdy = rdy[i];
      #1;
      checks++;
      if (obs() !== ex[i]) begin
        errors++; $display("FAIL st cyc%0d got %h exp %h", i, obs(), ex[i]);
      end
    end
  endtask

  task automatic test_br(input logic cond);
    logic [26:0] ex [8];
    ex = '{E_T0, E_T1R, E_T2, E_BR3, E_BR4, E_C4, (cond ? E_BR6T : E_BR6N), E_T0};
    opcode = 5'b10010; mem_rdy = 1'b1; con_ff = cond;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clock); #1;
      checks++;
      if (obs() !== ex[i]) begin
        errors++; $display("FAIL br_con%0b cyc%0d got %h exp %h", cond, i, obs(), ex[i]);
      end
    end
    con_ff = 1'b0;
  endtask

  task automatic test_nop_illegal(input logic [4:0] op, input logic [26:0] t3);
    logic [26:0] ex [5];
    ex = '{E_T0, E_T1R, E_T2, t3, E_T0};
    opcode = op; mem_rdy = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); #1;
      checks++;
      if (obs() !== ex[i]) begin
        errors++; $display("FAIL op%b cyc%0d got %h exp %h", op, i, obs(), ex[i]);
      end
    end
  endtask

  // halt: run drops the cycle after T3 and stays low, mem_rdy toggling
  task automatic test_halt();
    logic [26:0] ex [24];
    for (int i = 0; i < 24; i++) ex[i] = E_HALT;
    ex[0] = E_T0; ex[1] = E_T1R; ex[2] = E_T2; ex[3] = E_IDLE;
    opcode = 5'b11010;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      mem_rdy = i[0];
      if (i < 3) mem_rdy = 1'b1;
      #1;
      checks++;
      if (obs() !== ex[i]) begin
        errors++; $display("FAIL halt cyc%0d got %h exp %h", i, obs(), ex[i]);
      end
    end
    mem_rdy = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_andi();
    test_ld();
    test_st();
    test_br(1'b1);
    test_br(1'b0);
    test_nop_illegal(5'b11001, E_IDLE);
    test_nop_illegal(5'b11111, E_ILL);
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
